fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter ADDR_W, default 8: instruction address width.
REQ-002 Parameter INSTR_W, default 24: instruction word width.
REQ-003 Parameter RESET_PC, default 8'h00: first fetch address after reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 imem_addr  output  ADDR_W  address to combinational instruction memory; equals internal pc.
REQ-007 imem_data  input  INSTR_W  instruction word from memory, valid in the same cycle as imem_addr.
REQ-008 instr  output  INSTR_W  registered instruction to decode.
REQ-009 instr_pc  output  ADDR_W  address instr was fetched from.
REQ-010 instr_valid  output  1  instr/instr_pc hold a valid instruction.
REQ-011 instr_ready  input  1  decode accepts instr this cycle.
REQ-012 redirect_valid  input  1  branch/jump request; single-cycle pulse.
REQ-013 redirect_pc  input  ADDR_W  branch/jump target.
REQ-014 halt_req  input  1  stop fetching.
REQ-015 resume  input  1  restart fetching from current pc.
REQ-016 halted  output  1  controller is in HALTED state.
REQ-017 fetch_count  output  16  number of instructions loaded into instr since reset, saturating.

Function
REQ-018 States: FETCH, HALTED; only these two; reset enters FETCH.
REQ-019 Transfer occurs in a cycle where instr_valid && instr_ready.
REQ-020 Load condition: state FETCH, !redirect_valid, and (!instr_valid or transfer); on load, instr<=imem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1, fetch_count+1.
REQ-021 No load and transfer: instr_valid<=0; instr/instr_pc hold last value.
REQ-022 No load and no transfer: instr, instr_pc, instr_valid hold (back-pressure); imem_addr stable.
REQ-023 pc increments modulo 2^ADDR_W: 8'hFF -> 8'h00, no flag.
REQ-024 Redirect (any state): pc<=redirect_pc, instr_valid<=0 (flush, overrides held or transferred instruction), no load that cycle; first instruction from target becomes valid one cycle later if in FETCH.
REQ-025 halt_req in FETCH: FETCH->HALTED next edge; no load in that cycle; pending instr remains until transferred.
REQ-026 HALTED: no loads; pc changes only by redirect; halted=1.
REQ-027 resume in HALTED: HALTED->FETCH next edge; loading restarts the following cycle from pc.
REQ-028 halt_req and resume together: halt_req wins (remain/enter HALTED).
REQ-029 halt_req and redirect_valid together: redirect applied and state becomes HALTED.
REQ-030 fetch_count saturates at 16'hFFFF.
REQ-031 Throughput: one instruction per cycle while instr_ready held high in FETCH.

Reset
REQ-032 rst_n low asynchronously forces: pc=RESET_PC, imem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, state FETCH, halted=0, fetch_count=0.
REQ-033 Reset mid-operation discards pending instr and redirect; first load at first rising edge with rst_n high, fetching RESET_PC.

Structure
REQ-034 Shared package fetch_pkg holds ADDR_W/INSTR_W defaults, RESET_PC default and state enum type fetch_state_t.
REQ-035 Single module, no sub-module; instruction_memory instantiated alongside (bench/top), not inside.

Verification (memory preloaded mem[i]=24'hA00000+i)
REQ-036 Reset release, instr_ready=1 for 4 cycles -> instr_pc 00,01,02,03 consecutive cycles, instr A00000..A00003, fetch_count=4.
REQ-037 instr_valid with instr_pc=02, instr_ready=0 for 3 cycles -> instr=A00002 held, imem_addr=03 stable; ready=1 -> next instr_pc=03.
REQ-038 redirect_valid pulse, redirect_pc=8'h40, while instr_pc=05 valid -> instr_valid=0 next cycle, then instr_pc=40, instr=A00040.
REQ-039 redirect to 8'hFE, ready=1 -> instr_pc FE, FF, 00, 01 (wrap).
REQ-040 halt_req at instr_pc=10 -> halted=1, no further loads; resume -> instr_pc=11 two cycles later; halt_req+resume together -> stays halted.
REQ-041 rst_n low asynchronously mid-stream with instr_valid=1 -> instr_valid=0, imem_addr=00 immediately, without clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: parameter defaults,
// the controller state type and a saturating counter helper.
package fetch_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int INSTR_W_DEF  = 24;
  localparam int RESET_PC_DEF = 0;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch controller: one-entry instruction register in front of a
// combinational instruction memory, with redirect, halt/resume and back-pressure.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  input  logic               resume,
  output logic               halted,
  output logic [15:0]        fetch_count
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               instr_valid_q, instr_valid_d;
  logic [15:0]        fetch_count_q, fetch_count_d;
  logic               transfer;
  logic               load;

  assign transfer = instr_valid_q && instr_ready;

  // A halt request blocks the load in the same cycle it enters HALTED.
  assign load = (state_q == FETCH) && !redirect_valid && !halt_req
                && (!instr_valid_q || transfer);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fetch_count_d = fetch_count_q;

    if (halt_req) begin
      state_d = HALTED;
    end else if (state_q == HALTED && resume) begin
      state_d = FETCH;
    end

    // Redirect flushes whatever is held, even an instruction being accepted.
    if (redirect_valid) begin
      pc_d          = redirect_pc;
      instr_valid_d = 1'b0;
    end else if (load) begin
      instr_d       = imem_data;
      instr_pc_d    = pc_q;
      instr_valid_d = 1'b1;
      pc_d          = pc_q + ADDR_W'(1);
      fetch_count_d = sat_inc16(fetch_count_q);
    end else if (transfer) begin
      instr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = (state_q == HALTED);
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a reference model.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  imem_addr;
  logic [23:0] imem_data;
  logic [23:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic        halted;
  logic [15:0] fetch_count;

  int total = 0;
  int bad   = 0;

  fetch_controller #(.ADDR_W(8), .INSTR_W(24), .RESET_PC(8'h00)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .resume         (resume),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // Preloaded memory image: mem[i] = A00000 + i.
  assign imem_data = 24'hA00000 + {16'h0000, imem_addr};

  // Reference model: the slot holds at most one instruction; the next
  // instruction is taken when fetching, not redirected, not halting and the
  // slot is empty or being drained this cycle.
  int m_pc     = 0;
  int m_ipc    = 0;
  int m_loads  = 0;
  bit m_valid  = 0;
  bit m_halt   = 0;
  bit m_loaded = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 0; m_ipc = 0; m_loads = 0;
      m_valid = 0; m_halt = 0; m_loaded = 0;
    end else begin
      bit slot_free;
      bit take;
      slot_free = !m_valid || instr_ready;
      take = !m_halt && !redirect_valid && !halt_req && slot_free;
      if (redirect_valid) begin
        m_pc = int'(redirect_pc);
        m_valid = 0;
      end else if (take) begin
        m_ipc = m_pc;
        m_pc = (m_pc + 1) % 256;
        m_valid = 1;
        m_loaded = 1;
        m_loads++;
      end else if (m_valid && instr_ready) begin
        m_valid = 0;
      end
      if (halt_req) m_halt = 1;
      else if (resume) m_halt = 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model while out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("imem_addr", 32'(imem_addr), 32'(m_pc));
      checkOutput("instr_valid", 32'(instr_valid), 32'(m_valid));
      checkOutput("instr_pc", 32'(instr_pc), 32'(m_ipc));
      checkOutput("instr", 32'(instr), m_loaded ? 32'h00A00000 + 32'(m_ipc) : 32'h0);
      checkOutput("halted", 32'(halted), 32'(m_halt));
      checkOutput("fetch_count", 32'(fetch_count), (m_loads > 65535) ? 32'hFFFF : 32'(m_loads));
    end
  end

  // Drive one cycle of inputs from a negedge and return at the next negedge.
  task automatic applyStimulus(input logic rdy, input logic rv, input logic [7:0] rpc,
                               input logic hlt, input logic res);
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = hlt;
    resume         = res;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", 32'(instr_valid), 32'h0);
    checkOutput("rst_addr", 32'(imem_addr), 32'h0);
    checkOutput("rst_instr", 32'(instr), 32'h0);
    checkOutput("rst_ipc", 32'(instr_pc), 32'h0);
    checkOutput("rst_halted", 32'(halted), 32'h0);
    checkOutput("rst_count", 32'(fetch_count), 32'h0);
    rst_n = 1'b1;

    // Streaming with ready held high, then back-pressure at instr_pc=02.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("stream_ipc", 32'(instr_pc), 32'(k));
      checkOutput("stream_instr", 32'(instr), 32'h00A00000 + 32'(k));
      checkOutput("stream_valid", 32'(instr_valid), 32'h1);
    end
    checkOutput("model_ipc_pin", 32'(m_ipc), 32'h2);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("bp_instr", 32'(instr), 32'hA00002);
      checkOutput("bp_addr", 32'(imem_addr), 32'h03);
      checkOutput("bp_valid", 32'(instr_valid), 32'h1);
    end
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("bp_release_ipc", 32'(instr_pc), 32'h03);
    checkOutput("count4", 32'(fetch_count), 32'h4);
    checkOutput("model_count_pin", 32'(m_loads), 32'h4);

    // Redirect to 40 while instr_pc=05 is held.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("pre_redir_ipc", 32'(instr_pc), 32'h05);
    applyStimulus(1'b0, 1'b1, 8'h40, 1'b0, 1'b0);
    checkOutput("redir_flush", 32'(instr_valid), 32'h0);
    checkOutput("redir_addr", 32'(imem_addr), 32'h40);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("redir_ipc", 32'(instr_pc), 32'h40);
    checkOutput("redir_instr", 32'(instr), 32'hA00040);

    // Wrap of pc from FF to 00.
    applyStimulus(1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    checkOutput("wrap_flush", 32'(instr_valid), 32'h0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("wrap_ipc", 32'(instr_pc), 32'((8'hFE + k) % 256));
    end

    // Halt with a pending instruction, combined halt+resume, then resume.
    applyStimulus(1'b1, 1'b1, 8'h10, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("halt_pre_ipc", 32'(instr_pc), 32'h10);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("halt_flag", 32'(halted), 32'h1);
    checkOutput("halt_pending", 32'(instr_valid), 32'h1);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("halt_addr", 32'(imem_addr), 32'h11);
      checkOutput("halt_ipc", 32'(instr_pc), 32'h10);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("halt_wins", 32'(halted), 32'h1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("resume_flag", 32'(halted), 32'h0);
    checkOutput("resume_drain", 32'(instr_valid), 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("resume_ipc", 32'(instr_pc), 32'h11);
    checkOutput("model_resume_pin", 32'(m_ipc), 32'h11);

    // Asynchronous reset mid-stream, observed before any clock edge.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(instr_valid), 32'h0);
    checkOutput("arst_addr", 32'(imem_addr), 32'h0);
    checkOutput("arst_count", 32'(fetch_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        logic [7:0] tgt;
        tgt = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom_range(0, 255));
        applyStimulus($urandom_range(0, 3) != 0,
                      $urandom_range(0, 9) == 0,
                      tgt,
                      $urandom_range(0, 19) == 0,
                      $urandom_range(0, 5) == 0);
      end
    end

    // Saturation of fetch_count with continuous streaming.
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    instr_ready = 1'b1; redirect_valid = 1'b0; halt_req = 1'b0; resume = 1'b0;
    repeat (65540) @(negedge clk);
    checkOutput("count_sat", 32'(fetch_count), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
